hs32_prefetch_q: RTL and testbench
==================================

HS32_PREFETCH_Q -- requirements
Module: hs32_prefetch_q

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 2: queue holds 2**DEPTH_LOG2 entries.
REQ-002 SHALL have parameter MAX_OUT, default 2: maximum memory requests in flight, range 1..2**DEPTH_LOG2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-004 SHALL have port clk, input, 1: clock, all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port addr, output, 32: fetch address, equal to internal pc.
REQ-007 SHALL have port reqm, output, 1: fetch request valid.
REQ-008 SHALL have port ackm, input, 1: arbiter accepts addr this cycle; meaningful only when reqm=1.
REQ-009 SHALL have port dtr, input, 32: returned instruction word.
REQ-010 SHALL have port rdym, input, 1: dtr valid; responses return in request order.
REQ-011 SHALL have port instd, output, 32: head instruction.
REQ-012 SHALL have port pcd, output, 32: address of head instruction.
REQ-013 SHALL have port rdyd, output, 1: head entry valid.
REQ-014 SHALL have port reqd, input, 1: decode takes head when rdyd=1.
REQ-015 SHALL have port newpc, input, 32: redirect target.
REQ-016 SHALL have port flush, input, 1: redirect strobe.
REQ-017 SHALL have port level, output, DEPTH_LOG2+1: current queue fill.

Function
REQ-018 SHALL keep pointers wp/rp DEPTH_LOG2+1 bits wide, wrapping modulo 2**(DEPTH_LOG2+1); fill = wp-rp.
REQ-019 SHALL drive reqm = reset & !flush & (fill+outst < 2**DEPTH_LOG2) & (outst < MAX_OUT); outst counts issued, unreturned, undropped requests.
REQ-020 SHALL, on reqm&ackm, set pc <= pc+4 (mod 2**32) and increment outst; addr SHALL hold stable while reqm=1 and ackm=0.
REQ-021 SHALL, on rdym with drop=0, write {ret_pc,dtr} to fifo[wp], wp++, outst--, ret_pc += 4.
REQ-022 SHALL, on rdym with drop>0, discard dtr and decrement drop; no other state changes.
REQ-023 SHALL handle ackm and a non-dropped rdym in the same cycle with outst unchanged.
REQ-024 SHALL drive rdyd = (fill != 0); instd/pcd SHALL show fifo[rp]; rdym-to-rdyd latency is exactly 1 cycle; no bypass.
REQ-025 SHALL, on reqd&rdyd, increment rp; reqd while rdyd=0 is ignored.
REQ-026 SHALL allow a simultaneous read and write in any cycle, including at fill = 2**DEPTH_LOG2-1 or fill = 1.
REQ-027 SHALL, on flush=1 (priority over all else), set pc <= {newpc[31:2],2'b00}, ret_pc likewise, wp<=rp<=0, outst<=0, and drop <= drop+outst-(rdym?1:0).
REQ-028 SHALL discard any rdym arriving in the flush cycle; reqd in the flush cycle has no effect.
REQ-029 SHALL resume issuing requests to the new pc in the cycle after flush; back-to-back flushes accumulate drop correctly.

Reset
REQ-030 SHALL, while reset=0, set pc=ret_pc=RESET_PC, wp=rp=outst=drop=0, and force reqm=0, rdyd=0, level=0.
REQ-031 SHALL ignore rdym and ackm while reset=0; the arbiter shares this reset, so no response survives it.
REQ-032 SHALL leave fifo storage uninitialised; reset SHALL NOT be needed on it.

Structure
REQ-033 SHALL take INSN_BYTES (4) and the default RESET_PC from shared package hs32_pkg.
REQ-034 SHALL place storage in one sub-module hs32_pf_fifo: 2**DEPTH_LOG2 x 64-bit, with 1 write port and 1 asynchronous read port.
REQ-035 SHALL size the drop counter to hold 2*MAX_OUT without overflow.

Verification
REQ-036 SHALL cover fill-to-full: reset, RESET_PC=0, ackm=1, rdym one cycle after each ack, reqd=0 -> 4 entries at pc 0,4,8,C; reqm=0; level=4.
REQ-037 SHALL cover stall: ackm=0 for 5 cycles with reqm=1 -> addr constant; on ackm=1, pc advances by exactly 4.
REQ-038 SHALL cover flush with 2 in flight: newpc=32'h103 -> the next 2 rdym are discarded; the first accepted entry has pcd=32'h100.
REQ-039 SHALL cover flush coinciding with rdym and reqd: that word is dropped; rp=wp=0; drop=outst-1.
REQ-040 SHALL cover streaming: reqd=1 every cycle at 1 word/cycle -> level stays at 1 or below and the instd sequence matches the address order exactly.
REQ-041 SHALL cover mid-run reset: reset=0 for 1 cycle while 2 requests are in flight -> next addr=RESET_PC, rdyd=0, and no stale entry appears.

Source files
------------

// File: rtl/hs32_pkg.sv
// Shared HS32 constants used by the front-end blocks.
package hs32_pkg;

    localparam logic [31:0] INSN_BYTES       = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/hs32_pf_fifo.sv
// Prefetch queue storage: one write port, one asynchronous read port, no reset.
module hs32_pf_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [63:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [63:0]           rdata
);

    logic [63:0] mem [1 << DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hs32_prefetch_q.sv
// HS32 instruction prefetch queue: issues in-order fetches, buffers returned
// words with their addresses, and discards responses that belong to a redirect.
module hs32_prefetch_q
    import hs32_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 2,
    parameter int          MAX_OUT    = 2,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [31:0]           addr,
    output logic                  reqm,
    input  logic                  ackm,
    input  logic [31:0]           dtr,
    input  logic                  rdym,
    output logic [31:0]           instd,
    output logic [31:0]           pcd,
    output logic                  rdyd,
    input  logic                  reqd,
    input  logic [31:0]           newpc,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int DROP_W = $clog2(2 * MAX_OUT + 1);

    localparam logic [DEPTH_LOG2:0] PTR_ONE  = 1;
    localparam logic [OUT_W-1:0]    OUT_ONE  = 1;
    localparam logic [DROP_W-1:0]   DROP_ONE = 1;

    logic [31:0]         pc;
    logic [31:0]         ret_pc;
    logic [31:0]         target;
    logic [DEPTH_LOG2:0] wp;
    logic [DEPTH_LOG2:0] rp;
    logic [DEPTH_LOG2:0] fill;
    logic [OUT_W-1:0]    outst;
    logic [DROP_W-1:0]   drop;
    logic                accept;
    logic                keep;
    logic                take;
    logic [63:0]         head;

    assign fill   = wp - rp;
    assign target = newpc & ~(INSN_BYTES - 32'd1);

    // Room is reserved for every in-flight request so a returning word always has a slot.
    assign reqm = reset & ~flush
                  & ((32'(fill) + 32'(outst)) < 32'(DEPTH))
                  & (32'(outst) < 32'(MAX_OUT));

    assign accept = reqm & ackm;
    assign keep   = reset & ~flush & rdym & (drop == '0);
    assign rdyd   = reset & (fill != '0);
    assign take   = reqd & rdyd & ~flush;
    assign level  = reset ? fill : '0;
    assign addr   = pc;
    assign instd  = head[31:0];
    assign pcd    = head[63:32];

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= RESET_PC;
            ret_pc <= RESET_PC;
            wp     <= '0;
            rp     <= '0;
            outst  <= '0;
            drop   <= '0;
        end else if (flush) begin
            // Everything still in flight, minus a word arriving right now, becomes stale.
            pc     <= target;
            ret_pc <= target;
            wp     <= '0;
            rp     <= '0;
            outst  <= '0;
            drop   <= drop + DROP_W'(outst) - DROP_W'(rdym);
        end else begin
            if (accept) begin
                pc <= pc + INSN_BYTES;
            end
            if (keep) begin
                wp     <= wp + PTR_ONE;
                ret_pc <= ret_pc + INSN_BYTES;
            end
            if (rdym && (drop != '0)) begin
                drop <= drop - DROP_ONE;
            end
            if (take) begin
                rp <= rp + PTR_ONE;
            end
            case ({accept, keep})
                2'b10:   outst <= outst + OUT_ONE;
                2'b01:   outst <= outst - OUT_ONE;
                default: outst <= outst;
            endcase
        end
    end

    hs32_pf_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .we    (keep),
        .waddr (wp[DEPTH_LOG2-1:0]),
        .wdata ({ret_pc, dtr}),
        .raddr (rp[DEPTH_LOG2-1:0]),
        .rdata (head)
    );

endmodule

// File: tb/tb_hs32_prefetch_q.sv
// Scoreboard bench for the prefetch queue with an in-order memory model
// that tags in-flight requests stale on redirect.
module tb_hs32_prefetch_q;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        reqm;
    logic        ackm;
    logic [31:0] dtr;
    logic        rdym;
    logic [31:0] instd;
    logic [31:0] pcd;
    logic        rdyd;
    logic        reqd;
    logic [31:0] newpc;
    logic        flush;
    logic [2:0]  level;

    always #5 clk = ~clk;

    hs32_prefetch_q dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .reqm  (reqm),
        .ackm  (ackm),
        .dtr   (dtr),
        .rdym  (rdym),
        .instd (instd),
        .pcd   (pcd),
        .rdyd  (rdyd),
        .reqd  (reqd),
        .newpc (newpc),
        .flush (flush),
        .level (level)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          due;
        bit          stale;
    } mem_t;

    mem_t        mem_q[$];
    logic [31:0] sb_q[$];

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] exp_pc = RST_PC;

    bit          ack_v = 0;
    bit          flush_v = 0;
    bit          reqd_v = 0;
    bit          reset_v = 0;
    bit          resp_en = 1;
    logic [31:0] newpc_v = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
    endfunction

    function automatic int live_count();
        int n = 0;
        foreach (mem_q[i]) if (!mem_q[i].stale) n++;
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive at negedge, check before posedge, update models after it.
    task automatic applyStimulus();
        bit          rd;
        bit          exp_reqm;
        bit          exp_take;
        bit          acc;
        logic [31:0] a_cap;
        mem_t        h;
        reset = reset_v;
        ackm  = ack_v;
        flush = flush_v;
        newpc = newpc_v;
        reqd  = reqd_v;
        rd    = reset_v && resp_en && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        rdym  = rd;
        dtr   = rd ? word_of(mem_q[0].addr) : 32'h0;
        #1;
        exp_reqm = reset_v && !flush_v && ((sb_q.size() + live_count()) < 4) && (live_count() < 2);
        checkOutput("reqm", 32'(reqm), 32'(exp_reqm));
        checkOutput("rdyd", 32'(rdyd), 32'(reset_v && (sb_q.size() != 0)));
        checkOutput("level", 32'(level), reset_v ? 32'(sb_q.size()) : 32'd0);
        if (exp_reqm) checkOutput("addr", addr, exp_pc);
        exp_take = reset_v && !flush_v && reqd_v && (sb_q.size() != 0);
        if (exp_take) begin
            checkOutput("pcd", pcd, sb_q[0]);
            checkOutput("instd", instd, word_of(sb_q[0]));
        end
        acc   = reqm && ackm;
        a_cap = addr;
        @(posedge clk);
        if (!reset_v) begin
            mem_q.delete();
            sb_q.delete();
            exp_pc = RST_PC;
        end else begin
            if (rd) begin
                h = mem_q.pop_front();
                if (!flush_v && !h.stale) sb_q.push_back(h.pc);
            end
            if (exp_take) void'(sb_q.pop_front());
            if (acc) begin
                mem_q.push_back('{addr: a_cap, pc: exp_pc, due: cyc + lat, stale: 1'b0});
                exp_pc = exp_pc + 32'd4;
            end
            if (flush_v) begin
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                sb_q.delete();
                exp_pc = newpc_v & ~32'd3;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        reset = 1'b0; ackm = 1'b0; flush = 1'b0; reqd = 1'b0;
        rdym = 1'b0; dtr = 32'h0; newpc = 32'h0;
        @(negedge clk);
        run(3);
        reset_v = 1;

        // Fill to full with one-cycle responses and no consumer.
        ack_v = 1;
        run(8);
        checkOutput("full_level", 32'(level), 32'd4);
        checkOutput("full_reqm", 32'(reqm), 32'd0);
        ack_v = 0; reqd_v = 1;
        run(5);
        reqd_v = 0;

        // Arbiter stall, then a single grant.
        run(5);
        ack_v = 1; run(1);
        ack_v = 0; run(3);
        reqd_v = 1; run(2); reqd_v = 0;

        // Redirect with two requests in flight.
        resp_en = 0; ack_v = 1; run(3);
        ack_v = 0; flush_v = 1; newpc_v = 32'h103; run(1);
        flush_v = 0; resp_en = 1; ack_v = 1; run(6);
        reqd_v = 1; ack_v = 0; run(6); reqd_v = 0;

        // Redirect in the same cycle as a returning word and a consumer read.
        resp_en = 0; ack_v = 1; run(2);
        resp_en = 1; run(1);
        resp_en = 0; run(1);
        ack_v = 0; resp_en = 1; flush_v = 1; reqd_v = 1; newpc_v = 32'h200; run(1);
        flush_v = 0; reqd_v = 0;
        checkOutput("flush_level", 32'(level), 32'd0);
        ack_v = 1; run(6);
        reqd_v = 1; ack_v = 0; run(6);

        // Streaming at one word per cycle.
        ack_v = 1; reqd_v = 1; lat = 1;
        for (int i = 0; i < 20; i++) begin
            run(1);
            checkOutput("stream_level", 32'(level <= 3'd1), 32'd1);
        end

        // Reset with two requests in flight.
        reqd_v = 0; resp_en = 0; ack_v = 1; run(2);
        reset_v = 0; run(1);
        reset_v = 1; resp_en = 1;
        checkOutput("rst_addr", addr, RST_PC);
        checkOutput("rst_rdyd", 32'(rdyd), 32'd0);
        run(8);
        reqd_v = 1; ack_v = 0; run(6);

        // Randomised traffic with occasional redirects and resets.
        for (int i = 0; i < 400; i++) begin
            ack_v   = ($urandom_range(0, 3) != 0);
            reqd_v  = ($urandom_range(0, 2) != 0);
            resp_en = ($urandom_range(0, 3) != 0);
            lat     = $urandom_range(1, 3);
            flush_v = ($urandom_range(0, 15) == 0) && (mem_q.size() <= 2);
            newpc_v = $urandom;
            reset_v = ($urandom_range(0, 63) != 0);
            run(1);
        end
        reset_v = 1; flush_v = 0; ack_v = 0; resp_en = 1; reqd_v = 1;
        run(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
